// File: rtl/qspi_host_if.sv
// Request/response handshake and QSPI pad bundle for qspi_host.
// master: the host controller side. slave: the requester / pad side.
interface qspi_host_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_cmd_i;
  logic        req_addr_en_i;
  logic [31:0] req_addr_i;
  logic [4:0]  req_dummy_i;
  logic        req_write_i;
  logic [2:0]  req_nbytes_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        spi_sck_o;
  logic        spi_cs_o;
  logic [3:0]  spi_io_o;
  logic        spi_io_oe;
  logic [3:0]  spi_io_i;

  modport master (
    input  req_valid_i, req_cmd_i, req_addr_en_i, req_addr_i, req_dummy_i,
           req_write_i, req_nbytes_i, req_wdata_i, spi_io_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, spi_sck_o, spi_cs_o,
           spi_io_o, spi_io_oe
  );

  modport slave (
    output req_valid_i, req_cmd_i, req_addr_en_i, req_addr_i, req_dummy_i,
           req_write_i, req_nbytes_i, req_wdata_i, spi_io_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, spi_sck_o, spi_cs_o,
           spi_io_o, spi_io_oe
  );
endinterface

// File: rtl/qspi_host.sv
// QSPI initiator, SPI mode 0. One request at a time: CMD, optional quad
// ADDR, optional DUMMY, 0-4 quad DATA bytes, then CS hold and CS-high gap.
// Optional feature macro: QSPI_HOST_QUAD_CMD_EN (quad command phase,
// 2 SCK cycles instead of 8 single-bit cycles on IO0).
module qspi_host #(
  parameter int CLK_DIV        = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  qspi_host_if.master bus
);

`ifdef QSPI_HOST_QUAD_CMD_EN
  localparam int CMD_BITS = 4;
`else
  localparam int CMD_BITS = 1;
`endif
  localparam logic [5:0]    CMD_CYC  = 6'(8 / CMD_BITS);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam int            HW       = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END, S_CSH
  } state_t;

  state_t        state, state_next, phase_next;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt;
  logic [5:0]    bit_cnt;   // SCK cycles left in the current phase
  logic          sck, cs, oe;
  logic [7:0]    cmd_sr;
  logic [31:0]   addr_sr, wdata_sr, rdata_sr;
  logic          addr_en, write;
  logic [4:0]    dummy;
  logic [2:0]    nbytes;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [3:0]    io;
  logic [3:0]    cmd_io;
  logic          accept, tick, shifting, rise, fall, last;
  logic [2:0]    nb_in;

  assign tick     = (div_cnt == DIV_MAX);
  assign shifting = (state == S_CMD) || (state == S_ADDR) ||
                    (state == S_DUMMY) || (state == S_DATA);
  assign rise     = shifting && tick && !sck;
  assign fall     = shifting && tick && sck;
  assign last     = fall && (bit_cnt == 6'd1);
  assign accept   = (state == S_IDLE) && bus.req_valid_i;
  assign nb_in    = (bus.req_nbytes_i > 3'd4) ? 3'd4 : bus.req_nbytes_i;

`ifdef QSPI_HOST_QUAD_CMD_EN
  assign cmd_io = cmd_sr[7:4];
`else
  assign cmd_io = {3'b000, cmd_sr[7]};
`endif

  // Pad drive: the top of the active shift register; data is advanced on
  // SCK falling edges so it is stable across the following rising edge.
  always_comb begin
    io = 4'h0;
    case (state)
      S_CMD:   io = cmd_io;
      S_ADDR:  io = addr_sr[31:28];
      S_DATA:  io = write ? wdata_sr[31:28] : 4'h0;
      default: io = 4'h0;
    endcase
  end

  // Next phase after the current one; phases with no SCK cycles are skipped.
  always_comb begin
    phase_next = S_END;
    if (state == S_CMD && addr_en)
      phase_next = S_ADDR;
    else if ((state == S_CMD || state == S_ADDR) && dummy != 5'd0)
      phase_next = S_DUMMY;
    else if (state != S_DATA && nbytes != 3'd0)
      phase_next = S_DATA;
  end

  // Sequencer next-state.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:                          if (accept) state_next = S_CMD;
      S_CMD, S_ADDR, S_DUMMY, S_DATA:  if (last) state_next = phase_next;
      S_END:                           if (tick) state_next = S_CSH;
      S_CSH:                           if (hold_cnt == '0) state_next = S_IDLE;
      default:                         state_next = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= S_IDLE;
    else           state <= state_next;
  end

  // Datapath: SCK divider, request latch, shift registers, pad control, response.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_cnt   <= '0;
      hold_cnt  <= '0;
      bit_cnt   <= '0;
      sck       <= 1'b0;
      cs        <= 1'b1;
      oe        <= 1'b0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_sr  <= '0;
      addr_en   <= 1'b0;
      write     <= 1'b0;
      dummy     <= '0;
      nbytes    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;

      if (shifting || state == S_END) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      else                            div_cnt <= '0;

      if (shifting && tick) sck <= ~sck;

      if (accept) begin
        cs       <= 1'b0;
        oe       <= 1'b1;
        cmd_sr   <= bus.req_cmd_i;
        addr_sr  <= bus.req_addr_i;
        addr_en  <= bus.req_addr_en_i;
        dummy    <= bus.req_dummy_i;
        write    <= bus.req_write_i;
        nbytes   <= nb_in;
        // Left-justify the n sent bytes so the shift always leaves from bit 31.
        wdata_sr <= bus.req_wdata_i << (6'd32 - {nb_in, 3'b000});
        rdata_sr <= '0;
        bit_cnt  <= CMD_CYC;
      end

      if (rise && state == S_DATA && !write)
        rdata_sr <= {rdata_sr[27:0], bus.spi_io_i};

      if (fall) begin
        if (!last) begin
          bit_cnt <= bit_cnt - 6'd1;
          case (state)
            S_CMD:   cmd_sr <= cmd_sr << CMD_BITS;
            S_ADDR:  addr_sr <= addr_sr << 4;
            S_DATA:  if (write) wdata_sr <= wdata_sr << 4;
            default: ;
          endcase
        end else begin
          case (phase_next)
            S_ADDR:  begin bit_cnt <= 6'd8;               oe <= 1'b1;  end
            S_DUMMY: begin bit_cnt <= {1'b0, dummy};      oe <= 1'b0;  end
            S_DATA:  begin bit_cnt <= {2'b00, nbytes, 1'b0}; oe <= write; end
            default: ;
          endcase
        end
      end

      if (state == S_END && tick) begin
        cs        <= 1'b1;
        oe        <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= (write || nbytes == 3'd0) ? '0 : rdata_sr;
        hold_cnt  <= HOLD_MAX;
      end

      if (state == S_CSH && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign bus.req_ready_o = (state == S_IDLE);
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_rdata;
  assign bus.spi_sck_o   = sck;
  assign bus.spi_cs_o    = cs;
  assign bus.spi_io_o    = io;
  assign bus.spi_io_oe   = oe;

endmodule

// File: tb/tb_qspi_host.sv
// Scoreboard bench for qspi_host: stimulus pushes the expected SPI edge
// stream, SCK count and response into queues; a pad monitor/responder and a
// response monitor pop and compare independently.
module tb_qspi_host;
  localparam int CLK_DIV        = 2;
  localparam int CS_HIGH_CYCLES = 4;
`ifdef QSPI_HOST_QUAD_CMD_EN
  localparam int CMD_CYC = 2;
`else
  localparam int CMD_CYC = 8;
`endif

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;

  qspi_host_if bus();

  qspi_host #(.CLK_DIV(CLK_DIV), .CS_HIGH_CYCLES(CS_HIGH_CYCLES)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [3:0] nib; logic oe; logic chk; } edge_t;
  typedef struct { logic [31:0] rd; int k; int n; } rd_t;

  edge_t       exp_edges[$];
  int          exp_cnt[$];
  logic [31:0] exp_rsp[$];
  rd_t         rd_q[$];

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_rsp = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Reference model: expected pad stream, SCK count and response per request.
  task automatic issue(input logic [7:0] cmd, input logic aen, input logic [31:0] addr,
                       input logic [4:0] dum, input logic wr, input logic [2:0] nb,
                       input logic [31:0] wdata, input logic [31:0] rd);
    int          n, k, w;
    logic [63:0] mask;
    edge_t       e;
    n    = (nb > 3'd4) ? 4 : int'(nb);
    k    = CMD_CYC + 8 * int'(aen) + int'(dum);
    mask = (64'd1 << (8 * n)) - 64'd1;
`ifdef QSPI_HOST_QUAD_CMD_EN
    for (int i = 1; i >= 0; i--) begin
      e.nib = cmd[4*i +: 4]; e.oe = 1'b1; e.chk = 1'b1; exp_edges.push_back(e);
    end
`else
    for (int i = 7; i >= 0; i--) begin
      e.nib = {3'b000, cmd[i]}; e.oe = 1'b1; e.chk = 1'b1; exp_edges.push_back(e);
    end
`endif
    if (aen)
      for (int i = 7; i >= 0; i--) begin
        e.nib = addr[4*i +: 4]; e.oe = 1'b1; e.chk = 1'b1; exp_edges.push_back(e);
      end
    for (int i = 0; i < int'(dum); i++) begin
      e.nib = 4'h0; e.oe = 1'b0; e.chk = 1'b0; exp_edges.push_back(e);
    end
    for (int j = 0; j < 2 * n; j++) begin
      e.nib = wdata[4*(2*n-1-j) +: 4]; e.oe = wr; e.chk = wr; exp_edges.push_back(e);
    end
    exp_cnt.push_back(k + 2 * n);
    exp_rsp.push_back((wr || n == 0) ? 32'h0 : (rd & mask[31:0]));
    rd_q.push_back('{rd & mask[31:0], k, n});

    @(negedge clk_i);
    bus.req_valid_i   = 1'b1;
    bus.req_cmd_i     = cmd;
    bus.req_addr_en_i = aen;
    bus.req_addr_i    = addr;
    bus.req_dummy_i   = dum;
    bus.req_write_i   = wr;
    bus.req_nbytes_i  = nb;
    bus.req_wdata_i   = wdata;
    w = 0;
    while (!bus.req_ready_o && w < 2000) begin @(negedge clk_i); w++; end
    if (w >= 2000) begin
      n_chk++;
      $display("FAIL accept_timeout: got no req_ready_o in 2000 cycles, required accept");
    end
    @(posedge clk_i); #1;
    bus.req_valid_i   = 1'b0;
    bus.req_cmd_i     = 8'($urandom);
    bus.req_addr_en_i = 1'($urandom);
    bus.req_addr_i    = $urandom;
    bus.req_dummy_i   = 5'($urandom);
    bus.req_write_i   = 1'($urandom);
    bus.req_nbytes_i  = 3'($urandom);
    bus.req_wdata_i   = $urandom;
    check("ready_drop", 32'(bus.req_ready_o), 32'd0);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_rsp.size() != 0 || !bus.req_ready_o) && w < 10000) begin
      @(negedge clk_i); w++;
    end
    if (w >= 10000) begin
      n_chk++;
      $display("FAIL idle_timeout: got %0d pending responses, required 0", exp_rsp.size());
    end
    repeat (2) @(negedge clk_i);
  endtask

  // Pad monitor and read responder.
  initial begin : spi_mon
    logic        psck, pcs, active, seen_txn;
    int          edges, gap, cyc, last_fall, cnt, bad, first_bad;
    logic [3:0]  onib[$];
    logic        ooe[$];
    logic [3:0]  bad_nib, bad_exp_nib;
    logic        bad_oe, bad_exp_oe;
    edge_t       e;
    rd_t         cur;
    psck = 1'b0; pcs = 1'b1; active = 1'b0; seen_txn = 1'b0;
    edges = 0; gap = 0; cyc = 0; last_fall = 0;
    bad_nib = 4'h0; bad_exp_nib = 4'h0; bad_oe = 1'b0; bad_exp_oe = 1'b0;
    cur = '{32'h0, 0, 0};
    bus.spi_io_i = 4'h0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!reset_ni) begin
        active = 1'b0; seen_txn = 1'b0; psck = 1'b0; pcs = 1'b1; gap = 0;
        onib.delete(); ooe.delete(); bus.spi_io_i = 4'h0;
        continue;
      end
      if (pcs && !bus.spi_cs_o) begin
        if (seen_txn) begin
          n_chk++;
          if (gap >= CS_HIGH_CYCLES) n_pass++;
          else $display("FAIL cs_gap: got %0d CS-high cycles, required >= %0d", gap, CS_HIGH_CYCLES);
        end
        if (rd_q.size() == 0) cur = '{32'h0, 0, 0};
        else cur = rd_q.pop_front();
        active = 1'b1; edges = 0; onib.delete(); ooe.delete();
      end
      if (active && !psck && bus.spi_sck_o) begin
        onib.push_back(bus.spi_io_o); ooe.push_back(bus.spi_io_oe); edges++;
      end
      if (active && psck && !bus.spi_sck_o) last_fall = cyc;
      if (active && !pcs && bus.spi_cs_o) begin
        if (exp_cnt.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_txn: got CS window with %0d SCK edges, required none", edges);
        end else begin
          cnt = exp_cnt.pop_front();
          check("sck_count", 32'(edges), 32'(cnt));
          bad = 0; first_bad = -1;
          for (int i = 0; i < cnt; i++) begin
            e = exp_edges.pop_front();
            if (i < edges && (ooe[i] !== e.oe || (e.chk && onib[i] !== e.nib))) begin
              if (first_bad < 0) begin
                first_bad = i; bad_nib = onib[i]; bad_oe = ooe[i];
                bad_exp_nib = e.nib; bad_exp_oe = e.oe;
              end
              bad++;
            end
          end
          n_chk++;
          if (bad == 0) n_pass++;
          else $display("FAIL io_stream: %0d bad edges, first #%0d got io=%h oe=%b, required io=%h oe=%b",
                        bad, first_bad, bad_nib, bad_oe, bad_exp_nib, bad_exp_oe);
          check("cs_hold", 32'(cyc - last_fall), 32'(CLK_DIV));
        end
        active = 1'b0; seen_txn = 1'b1; gap = 0;
      end
      if (bus.spi_cs_o) gap++;
      if (active && edges >= cur.k && edges < cur.k + 2 * cur.n)
        bus.spi_io_i = cur.rd[4*(2*cur.n-1-(edges-cur.k)) +: 4];
      else
        bus.spi_io_i = 4'($urandom);
      psck = bus.spi_sck_o;
      pcs  = bus.spi_cs_o;
    end
  end

  // Response monitor.
  initial begin : rsp_mon
    logic [31:0] req;
    forever begin
      @(negedge clk_i);
      if (reset_ni && bus.rsp_valid_o) begin
        if (exp_rsp.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: got rsp_valid_o rdata 0x%08h, required none", bus.rsp_rdata_o);
        end else begin
          req = exp_rsp.pop_front();
          check("rsp_rdata", bus.rsp_rdata_o, req);
          last_rsp = req;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion in 40000 cycles, required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.req_valid_i = 1'b0; bus.req_cmd_i = 8'h0; bus.req_addr_en_i = 1'b0;
    bus.req_addr_i = 32'h0; bus.req_dummy_i = 5'h0; bus.req_write_i = 1'b0;
    bus.req_nbytes_i = 3'h0; bus.req_wdata_i = 32'h0;
    reset_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_rdata", bus.rsp_rdata_o, 32'h0);
    check("rst_cs", 32'(bus.spi_cs_o), 32'd1);
    check("rst_sck", 32'(bus.spi_sck_o), 32'd0);
    check("rst_io", 32'(bus.spi_io_o), 32'd0);
    check("rst_oe", 32'(bus.spi_io_oe), 32'd0);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases, issued back to back.
    issue(8'h0B, 1'b1, 32'h00123456, 5'd4, 1'b0, 3'd4, 32'h0, 32'hDEADBEEF);
    issue(8'h02, 1'b1, 32'h00000010, 5'd0, 1'b1, 3'd2, 32'h0000A55A, 32'h0);
    issue(8'h06, 1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 32'h0, 32'hFFFFFFFF);
    issue(8'h6B, 1'b1, 32'h00ABCDEF, 5'd8, 1'b0, 3'd7, 32'h0, 32'h11223344);
    issue(8'hEB, 1'b0, 32'h0, 5'd0, 1'b0, 3'd1, 32'h0, 32'h0000005A);
    wait_idle();

    // Reset during the address phase aborts without a response.
    issue(8'h0B, 1'b1, 32'hCAFEF00D, 5'd8, 1'b0, 3'd4, 32'h0, $urandom);
    repeat (2 * CLK_DIV * (CMD_CYC + 3)) @(posedge clk_i);
    #2;
    check("pre_rst_cs_low", 32'(bus.spi_cs_o), 32'd0);
    reset_ni = 1'b0;
    #1;
    check("abort_cs", 32'(bus.spi_cs_o), 32'd1);
    check("abort_oe", 32'(bus.spi_io_oe), 32'd0);
    check("abort_sck", 32'(bus.spi_sck_o), 32'd0);
    exp_rsp.delete(); exp_edges.delete(); exp_cnt.delete(); rd_q.delete();
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("abort_ready", 32'(bus.req_ready_o), 32'd1);
    check("abort_rdata", bus.rsp_rdata_o, 32'h0);
    last_rsp = 32'h0;
    repeat (50) @(negedge clk_i);

    // Randomized requests.
    for (int t = 0; t < 20; t++) begin
      issue(8'($urandom), 1'($urandom),
            $urandom, ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    wait_idle();

    check("rdata_hold", bus.rsp_rdata_o, last_rsp);
    check("pending_rsp", 32'(exp_rsp.size()), 32'd0);
    check("pending_txn", 32'(exp_cnt.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
